// File: rtl/twi_xfer_sequencer_if.sv
// Signal bundle between twi_xfer_sequencer and its surroundings: descriptor,
// payload streams, TWI core register access and status.
interface twi_xfer_sequencer_if #(
  parameter int unsigned LEN_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [6:0]           cmd_addr;
  logic                 cmd_rd;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 cmd_hold;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [7:0]           wr_data;

  logic                 rd_valid;
  logic                 rd_ready;
  logic [7:0]           rd_data;

  logic                 twi_twint;
  logic [7:0]           twi_status;
  logic [7:0]           twi_rdata;
  logic [7:0]           twi_wdata;
  logic                 twi_wdata_we;
  logic                 twi_ctrl_we;
  logic                 twi_sta;
  logic                 twi_sto;
  logic                 twi_ea;

  logic                 busy;
  logic                 bus_held;
  logic                 done;
  logic                 err;
  logic [2:0]           err_code;

  // master: the sequencer itself
  modport master (
    input  cmd_valid, cmd_addr, cmd_rd, cmd_len, cmd_hold,
    input  wr_valid, wr_data, rd_ready,
    input  twi_twint, twi_status, twi_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output twi_wdata, twi_wdata_we, twi_ctrl_we, twi_sta, twi_sto, twi_ea,
    output busy, bus_held, done, err, err_code
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_rd, cmd_len, cmd_hold,
    output wr_valid, wr_data, rd_ready,
    output twi_twint, twi_status, twi_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  twi_wdata, twi_wdata_we, twi_ctrl_we, twi_sta, twi_sto, twi_ea,
    input  busy, bus_held, done, err, err_code
  );
endinterface

// File: rtl/twi_xfer_sequencer.sv
// Runs a full TWI master transaction (START, SLA+R/W, data, STOP) from one descriptor.
// Optional TWINT wait timeout is compiled in with `define TWI_SEQ_TIMEOUT_EN.
module twi_xfer_sequencer #(
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   reset,
  twi_xfer_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, START, W_START, ADDR, W_ADDR, WR_LOAD, W_WR,
    RD_ISSUE, W_RD, RD_PUSH, STOP, FIN
  } state_t;

  state_t               state, state_n;
  logic                 phase, phase_n;
  logic                 blank;
  logic [6:0]           addr_q, addr_n;
  logic                 rd_q, rd_n;
  logic                 hold_q, hold_n;
  logic [LEN_WIDTH-1:0] rem, rem_n;
  logic [2:0]           code_q, code_n;
  logic                 held_q, held_n;
  logic [7:0]           rdata_q, rdata_n;

  logic [7:0]           st;
  logic                 wait_st;
  logic                 evt;
  logic                 fail;
  logic [2:0]           fcode;
  logic                 ok_end;
  logic                 last;

  logic                 cmd_ready, ctrl_we, sta, sto, ea, wdata_we, wr_ready, rd_valid;
  logic [7:0]           wdata;

  assign st      = bus.twi_status & 8'hF8;
  assign wait_st = state inside {W_START, W_ADDR, W_WR, W_RD};
  // The first cycle after a control write still shows the stale TWINT.
  assign evt     = wait_st && bus.twi_twint && !blank;
  assign last    = (rem == LEN_WIDTH'(1));

`ifdef TWI_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = wait_st && !evt && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Every W_* state is entered right after a control write, so that clears it.
  always_ff @(posedge clk) begin
    if (reset || ctrl_we) tmo_cnt <= '0;
    else if (wait_st)     tmo_cnt <= tmo_cnt + 32'd1;
  end
`endif

  always_comb begin
    state_n   = state;
    phase_n   = 1'b0;
    addr_n    = addr_q;
    rd_n      = rd_q;
    hold_n    = hold_q;
    rem_n     = rem;
    code_n    = code_q;
    held_n    = held_q;
    rdata_n   = rdata_q;
    fail      = 1'b0;
    fcode     = 3'd0;
    ok_end    = 1'b0;
    cmd_ready = 1'b0;
    ctrl_we   = 1'b0;
    sta       = 1'b0;
    sto       = 1'b0;
    ea        = 1'b0;
    wdata_we  = 1'b0;
    wdata     = 8'h00;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;

    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_n  = bus.cmd_addr;
          rd_n    = bus.cmd_rd && (bus.cmd_len != '0);
          hold_n  = bus.cmd_hold;
          rem_n   = bus.cmd_len;
          code_n  = 3'd0;
          state_n = START;
        end
      end
      START: begin
        ctrl_we = 1'b1;
        sta     = 1'b1;
        state_n = W_START;
      end
      W_START: if (evt) begin
        if (st == (held_q ? 8'h10 : 8'h08)) state_n = ADDR;
        else begin fail = 1'b1; fcode = (st == 8'h38) ? 3'd3 : 3'd4; end
      end
      ADDR: begin
        if (!phase) begin
          wdata_we = 1'b1;
          wdata    = {addr_q, rd_q};
          phase_n  = 1'b1;
        end else begin
          ctrl_we  = 1'b1;
          state_n  = W_ADDR;
        end
      end
      W_ADDR: if (evt) begin
        if (st == (rd_q ? 8'h40 : 8'h18)) begin
          if (rem == '0) ok_end  = 1'b1;
          else           state_n = rd_q ? RD_ISSUE : WR_LOAD;
        end else begin
          fail  = 1'b1;
          if (st == 8'h20 || st == 8'h48) fcode = 3'd1;
          else if (st == 8'h38)           fcode = 3'd3;
          else                            fcode = 3'd4;
        end
      end
      WR_LOAD: begin
        if (!phase) begin
          if (bus.wr_valid) begin
            wr_ready = 1'b1;
            wdata_we = 1'b1;
            wdata    = bus.wr_data;
            phase_n  = 1'b1;
          end
        end else begin
          ctrl_we = 1'b1;
          state_n = W_WR;
        end
      end
      W_WR: if (evt) begin
        if (st == 8'h28 || (st == 8'h30 && last)) begin
          rem_n = rem - LEN_WIDTH'(1);
          if (last) ok_end  = 1'b1;
          else      state_n = WR_LOAD;
        end else begin
          fail  = 1'b1;
          if (st == 8'h30)      fcode = 3'd2;
          else if (st == 8'h38) fcode = 3'd3;
          else                  fcode = 3'd4;
        end
      end
      RD_ISSUE: begin
        ctrl_we = 1'b1;
        ea      = !last;
        state_n = W_RD;
      end
      W_RD: if (evt) begin
        if (st == (last ? 8'h58 : 8'h50)) begin
          rdata_n = bus.twi_rdata;
          state_n = RD_PUSH;
        end else begin
          fail  = 1'b1;
          fcode = (st == 8'h38) ? 3'd3 : 3'd4;
        end
      end
      RD_PUSH: begin
        rd_valid = 1'b1;
        if (bus.rd_ready) begin
          rem_n = rem - LEN_WIDTH'(1);
          if (last) ok_end  = 1'b1;
          else      state_n = RD_ISSUE;
        end
      end
      STOP: begin
        ctrl_we = 1'b1;
        sto     = 1'b1;
        held_n  = 1'b0;
        state_n = FIN;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase

`ifdef TWI_SEQ_TIMEOUT_EN
    if (tmo_hit) begin
      fail  = 1'b1;
      fcode = 3'd5;
    end
`endif

    // Lost arbitration means the bus is no longer ours: no STOP allowed.
    if (fail) begin
      code_n = fcode;
      if (fcode == 3'd3) begin
        held_n  = 1'b0;
        state_n = FIN;
      end else begin
        state_n = STOP;
      end
    end else if (ok_end) begin
      if (hold_q) begin
        held_n  = 1'b1;
        state_n = FIN;
      end else begin
        state_n = STOP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 1'b0;
      blank   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      hold_q  <= 1'b0;
      rem     <= '0;
      code_q  <= '0;
      held_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      blank   <= ctrl_we;
      addr_q  <= addr_n;
      rd_q    <= rd_n;
      hold_q  <= hold_n;
      rem     <= rem_n;
      code_q  <= code_n;
      held_q  <= held_n;
      rdata_q <= rdata_n;
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.wr_ready     = wr_ready;
  assign bus.rd_valid     = rd_valid;
  assign bus.rd_data      = rdata_q;
  assign bus.twi_wdata    = wdata;
  assign bus.twi_wdata_we = wdata_we;
  assign bus.twi_ctrl_we  = ctrl_we;
  assign bus.twi_sta      = sta;
  assign bus.twi_sto      = sto;
  assign bus.twi_ea       = ea;
  assign bus.busy         = (state != IDLE);
  assign bus.bus_held     = held_q;
  assign bus.done         = (state == FIN) && (code_q == 3'd0);
  assign bus.err          = (state == FIN) && (code_q != 3'd0);
  assign bus.err_code     = code_q;

endmodule

// File: tb/tb_twi_xfer_sequencer.sv
// Directed scoreboard bench for twi_xfer_sequencer with a behavioural TWI core responder.
`timescale 1ns/1ps
module tb_twi_xfer_sequencer;
  localparam int unsigned LW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  twi_xfer_sequencer_if #(.LEN_WIDTH(LW)) bus ();

  twi_xfer_sequencer #(.LEN_WIDTH(LW), .TIMEOUT_CYCLES(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [2:0]  exp_ctrl[$];   // {sta, sto, ea}
  logic [7:0]  exp_wd[$];
  logic [7:0]  exp_rd[$];
  logic [4:0]  exp_end[$];    // {done, err, err_code}
  logic [15:0] model_q[$];    // {status, rdata} returned per control write
  logic [7:0]  wr_src[$];
  int          ctrl_cnt = 0;
  int          end_cnt  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // TWI core responder: TWINT rises three cycles after each control write.
  int dly = 0;
  always @(negedge clk) begin
    if (reset) begin
      bus.twi_twint = 1'b0;
      dly = 0;
    end else if (bus.twi_ctrl_we) begin
      bus.twi_twint = 1'b0;
      dly = 3;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0 && model_q.size() != 0) begin
        {bus.twi_status, bus.twi_rdata} = model_q.pop_front();
        bus.twi_twint = 1'b1;
      end
    end
  end

  // Write payload source, changed just after the clock edge.
  logic wr_fire;
  always begin
    @(negedge clk);
    wr_fire = bus.wr_valid && bus.wr_ready;
    @(posedge clk);
    #1;
    if (wr_fire && wr_src.size() != 0) void'(wr_src.pop_front());
    bus.wr_valid = (wr_src.size() != 0);
    bus.wr_data  = (wr_src.size() != 0) ? wr_src[0] : 8'h00;
  end

  // Output monitor: pops the scoreboard as the DUT produces events.
  logic wd_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      wd_prev = 1'b0;
    end else begin
      if (wd_prev) chk("wdata_then_ctrl", 16'(bus.twi_ctrl_we), 16'd1);
      wd_prev = bus.twi_wdata_we;
      if (bus.twi_wdata_we) begin
        if (exp_wd.size() == 0) chk("wdata_unexpected", 16'(exp_wd.size()), 16'd1);
        else chk("wdata", 16'(bus.twi_wdata), 16'(exp_wd.pop_front()));
      end
      if (bus.twi_ctrl_we) begin
        ctrl_cnt++;
        if (exp_ctrl.size() == 0) chk("ctrl_unexpected", 16'(exp_ctrl.size()), 16'd1);
        else chk("ctrl_bits", 16'({bus.twi_sta, bus.twi_sto, bus.twi_ea}), 16'(exp_ctrl.pop_front()));
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 16'(exp_rd.size()), 16'd1);
        else chk("rd_data", 16'(bus.rd_data), 16'(exp_rd.pop_front()));
      end
      if (bus.done || bus.err) begin
        end_cnt++;
        if (exp_end.size() == 0) chk("end_unexpected", 16'(exp_end.size()), 16'd1);
        else chk("end_flags", 16'({bus.done, bus.err, bus.err_code}), 16'(exp_end.pop_front()));
      end
    end
  end

  task automatic send_cmd(input logic [6:0] a, input logic r, input logic [7:0] l, input logic h);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 16'(bus.cmd_ready), 16'd1);
    bus.cmd_addr  = a;
    bus.cmd_rd    = r;
    bus.cmd_len   = l;
    bus.cmd_hold  = h;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    // {ctrl_we, sta, busy, cmd_ready} one cycle after accept
    chk("start_latency", 16'({bus.twi_ctrl_we, bus.twi_sta, bus.busy, bus.cmd_ready}), 16'hE);
  endtask

  task automatic wait_end(input int lim);
    int s = end_cnt;
    int n = 0;
    while (end_cnt == s && n < lim) begin
      tick();
      n++;
    end
    chk("end_seen", 16'(end_cnt - s), 16'd1);
  endtask

  initial begin
    int c0;
    int n;
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_rd     = 1'b0;
    bus.cmd_len    = '0;
    bus.cmd_hold   = 1'b0;
    bus.rd_ready   = 1'b1;
    bus.twi_status = 8'h00;
    bus.twi_rdata  = 8'h00;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'h00;

    // Reset state
    tick(3);
    chk("reset_outputs", 16'({bus.cmd_ready, bus.busy, bus.bus_held, bus.done, bus.err,
        bus.twi_ctrl_we, bus.twi_wdata_we, bus.rd_valid, bus.wr_ready}), 16'h100);
    chk("reset_err_code", 16'(bus.err_code), 16'd0);
    reset = 1'b0;
    tick();

    // Write 2 bytes
    wr_src.push_back(8'hA5); wr_src.push_back(8'h3C);
    model_q.push_back(16'h0800); model_q.push_back(16'h1800);
    model_q.push_back(16'h2800); model_q.push_back(16'h2800);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b000);
    exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b010);
    exp_wd.push_back(8'hA0); exp_wd.push_back(8'hA5); exp_wd.push_back(8'h3C);
    exp_end.push_back(5'h10);
    send_cmd(7'h50, 1'b0, 8'd2, 1'b0);
    wait_end(300);
    chk("wr2_bus_held", 16'(bus.bus_held), 16'd0);

    // Read 3 bytes with a 10-cycle consumer stall on the first byte
    bus.rd_ready = 1'b0;
    model_q.push_back(16'h0800); model_q.push_back(16'h4000);
    model_q.push_back(16'h5011); model_q.push_back(16'h5022); model_q.push_back(16'h5833);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b001);
    exp_ctrl.push_back(3'b001); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b010);
    exp_wd.push_back(8'hA1);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    exp_end.push_back(5'h10);
    send_cmd(7'h50, 1'b1, 8'd3, 1'b0);
    n = 0;
    while (!bus.rd_valid && n < 100) begin
      tick();
      n++;
    end
    chk("rd_valid_wait", 16'(bus.rd_valid), 16'd1);
    c0 = ctrl_cnt;
    tick(10);
    chk("stall_no_ctrl", 16'(ctrl_cnt - c0), 16'd0);
    chk("stall_rd_hold", 16'({bus.rd_valid, bus.rd_data}), 16'h111);
    bus.rd_ready = 1'b1;
    wait_end(300);

    // Address NACK
    model_q.push_back(16'h0800); model_q.push_back(16'h2000);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b010);
    exp_wd.push_back(8'h74);
    exp_end.push_back(5'h09);
    send_cmd(7'h3A, 1'b0, 8'd1, 1'b0);
    wait_end(300);
    tick(2);
    chk("nack_code_held", 16'({bus.bus_held, bus.err_code}), 16'h1);

    // Held write, last byte NACKed (0x30 is fine on the last byte)
    wr_src.push_back(8'h5A);
    model_q.push_back(16'h0800); model_q.push_back(16'h1800); model_q.push_back(16'h3000);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b000);
    exp_wd.push_back(8'hA0); exp_wd.push_back(8'h5A);
    exp_end.push_back(5'h10);
    send_cmd(7'h50, 1'b0, 8'd1, 1'b1);
    wait_end(300);
    chk("hold_bus_held", 16'(bus.bus_held), 16'd1);

    // Repeated start read expecting 0x10
    model_q.push_back(16'h1000); model_q.push_back(16'h4000); model_q.push_back(16'h5877);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b000);
    exp_ctrl.push_back(3'b010);
    exp_wd.push_back(8'hA1);
    exp_rd.push_back(8'h77);
    exp_end.push_back(5'h10);
    send_cmd(7'h50, 1'b1, 8'd1, 1'b0);
    wait_end(300);
    chk("rs_read_released", 16'(bus.bus_held), 16'd0);

    // Zero-length probe with rd=1 and hold: goes out as SLA+W
    model_q.push_back(16'h0800); model_q.push_back(16'h1800);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000);
    exp_wd.push_back(8'hA0);
    exp_end.push_back(5'h10);
    send_cmd(7'h50, 1'b1, 8'd0, 1'b1);
    wait_end(300);
    chk("probe_bus_held", 16'(bus.bus_held), 16'd1);

    // Held bus, core reports a plain START: unexpected status
    model_q.push_back(16'h0800);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b010);
    exp_end.push_back(5'h0C);
    send_cmd(7'h50, 1'b1, 8'd1, 1'b0);
    wait_end(300);
    chk("badstart_released", 16'({bus.bus_held, bus.err_code}), 16'h4);

    // Data NACK before the last byte
    wr_src.push_back(8'h44);
    model_q.push_back(16'h0800); model_q.push_back(16'h1800); model_q.push_back(16'h3000);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b000);
    exp_ctrl.push_back(3'b010);
    exp_wd.push_back(8'hA0); exp_wd.push_back(8'h44);
    exp_end.push_back(5'h0A);
    send_cmd(7'h50, 1'b0, 8'd2, 1'b0);
    wait_end(300);

    // Arbitration lost after a data byte: no STOP
    wr_src.push_back(8'h11);
    model_q.push_back(16'h0800); model_q.push_back(16'h1800); model_q.push_back(16'h3800);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b000);
    exp_wd.push_back(8'hA0); exp_wd.push_back(8'h11);
    exp_end.push_back(5'h0B);
    send_cmd(7'h50, 1'b0, 8'd2, 1'b0);
    wait_end(300);
    tick(4);
    chk("arb_no_stop", 16'({bus.bus_held, bus.err_code}), 16'h3);

    // Held write, then reset in the middle of the following read
    wr_src.push_back(8'h66);
    model_q.push_back(16'h0800); model_q.push_back(16'h1800); model_q.push_back(16'h2800);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000); exp_ctrl.push_back(3'b000);
    exp_wd.push_back(8'hA0); exp_wd.push_back(8'h66);
    exp_end.push_back(5'h10);
    send_cmd(7'h50, 1'b0, 8'd1, 1'b1);
    wait_end(300);
    model_q.push_back(16'h1000);
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b000);
    exp_wd.push_back(8'hA1);
    send_cmd(7'h50, 1'b1, 8'd2, 1'b0);
    tick(12);
    chk("midread_busy", 16'({bus.busy, bus.bus_held}), 16'h3);
    reset = 1'b1;
    tick();
    chk("midreset_outputs", 16'({bus.cmd_ready, bus.busy, bus.bus_held, bus.done, bus.err,
        bus.twi_ctrl_we, bus.twi_wdata_we, bus.rd_valid, bus.wr_ready}), 16'h100);
    chk("midreset_data", 16'({bus.twi_wdata, bus.rd_data}), 16'h0000);
    chk("midreset_code", 16'(bus.err_code), 16'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

`ifdef TWI_SEQ_TIMEOUT_EN
    // TWINT never arrives: error 5 after the limit, then STOP
    exp_ctrl.push_back(3'b100); exp_ctrl.push_back(3'b010);
    exp_end.push_back(5'h0D);
    send_cmd(7'h10, 1'b0, 8'd1, 1'b0);
    wait_end(400);
`endif

    chk("scoreboard_drained", 16'(exp_ctrl.size() + exp_wd.size() + exp_rd.size()
        + exp_end.size() + model_q.size() + wr_src.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
